vospi_slave_tx: RTL and testbench

//  VoSPI slave transmitter (Lepton emulator): the far end of our SPI-mode-3 VoSPI capture master.

---
 rtl/vospi_slave_tx.sv | 194 +++++++++++++++++++
 tb/tb_vospi_slave_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vospi_slave_tx.sv
// VoSPI slave transmitter: AXI-S pixels into ping-pong line buffers, serialised as VoSPI packets (SPI mode 3). Optional VOSPI_CRC_EN adds per-line CRC-16-CCITT.
// Latency: spi_miso follows a pad spi_clk fall within SYNC_STAGES+1 clk; tready drops while the write buffer is full or on a buffer-release clk.
module vospi_slave_tx #(
  parameter int PIXELS_PER_LINE   = 80,
  parameter int PACKETS_PER_FRAME = 60,
  parameter int SYNC_STAGES       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic        frame_error,
  output logic [15:0] discard_count
);
  localparam int PKT_BYTES = 2 * PIXELS_PER_LINE + 4;
  localparam int WW        = $clog2(PIXELS_PER_LINE);
  localparam int BW        = $clog2(PKT_BYTES);
  localparam int AW        = $clog2(2 * PIXELS_PER_LINE);

  logic [15:0]      mem [2*PIXELS_PER_LINE];
  logic             run, wr_ptr, rd_ptr;
  logic [1:0]       buf_full;
  logic [1:0][11:0] buf_pkt;
  logic [WW-1:0]    wr_word;
  logic [11:0]      wr_line;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic             wr_hs, last_word, last_line, line_err, rel;
  logic [15:0]      rd_crc;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic             sclk_q, sclk_s, cs_s, fall, rise;
  logic             pkt_start, vid_now, is_video, last_bit;
  logic [2:0]       bit_idx;
  logic [BW-1:0]    byte_idx;
  logic [7:0]       tx_byte;
  logic [WW-1:0]    widx;
  logic [15:0]      rd_word;
  logic [11:0]      rd_pkt;

  // A release clk blocks the write side so free and fill never coincide
  assign s_axis_tready = run & en & ~buf_full[wr_ptr] & ~rel;
  assign wr_hs     = s_axis_tvalid & s_axis_tready;
  assign last_word = (wr_word == WW'(PIXELS_PER_LINE - 1));
  assign last_line = (wr_line == 12'(PACKETS_PER_FRAME - 1));
  assign line_err  = s_axis_tlast ? ~(last_word & last_line) : (last_word & last_line);
  assign wr_addr   = wr_ptr ? AW'(PIXELS_PER_LINE) + AW'(wr_word) : AW'(wr_word);

  always_ff @(posedge clk) begin
    if (wr_hs) mem[wr_addr] <= s_axis_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_full    <= '0;
      buf_pkt     <= '0;
      wr_word     <= '0;
      wr_line     <= '0;
      frame_error <= 1'b0;
    end else begin
      run <= 1'b1;
      if (rel) begin
        buf_full[rd_ptr] <= 1'b0;
        rd_ptr           <= ~rd_ptr;
      end
      if (wr_hs) begin
        if (line_err) begin
          frame_error <= 1'b1;
          wr_word     <= '0;
          wr_line     <= '0;
        end else if (last_word) begin
          buf_full[wr_ptr] <= 1'b1;
          buf_pkt[wr_ptr]  <= wr_line;
          wr_line          <= last_line ? 12'd0 : wr_line + 12'd1;
          wr_ptr           <= ~wr_ptr;
          wr_word          <= '0;
        end else begin
          wr_word <= wr_word + WW'(1);
        end
      end
    end
  end

`ifdef VOSPI_CRC_EN
  logic [1:0][15:0] buf_crc;
  logic [15:0]      crc_acc, crc_next;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  // First pixel of a line restarts from the ID bytes plus the zeroed CRC field
  always_comb begin
    crc_next = crc_acc;
    if (wr_word == '0)
      crc_next = crc_byte(crc_byte(crc_byte(crc_byte(16'h0000, {4'h0, wr_line[11:8]}),
                                            wr_line[7:0]), 8'h00), 8'h00);
    crc_next = crc_byte(crc_byte(crc_next, s_axis_tdata[15:8]), s_axis_tdata[7:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_acc <= '0;
      buf_crc <= '0;
    end else if (wr_hs) begin
      crc_acc <= crc_next;
      if (!line_err && last_word) buf_crc[wr_ptr] <= crc_next;
    end
  end

  assign rd_crc = buf_crc[rd_ptr];
`else
  assign rd_crc = 16'h0000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      sclk_q    <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_q    <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign fall      = ~cs_s & sclk_q & ~sclk_s;
  assign rise      = ~cs_s & ~sclk_q & sclk_s;
  assign pkt_start = fall & (byte_idx == '0) & (bit_idx == 3'd0);
  assign vid_now   = pkt_start ? (buf_full[rd_ptr] & en) : is_video;
  assign rel       = rise & last_bit & is_video;

  always_comb begin
    widx = '0;
    if (byte_idx >= BW'(4)) widx = WW'((byte_idx - BW'(4)) >> 1);
    rd_addr = rd_ptr ? AW'(PIXELS_PER_LINE) + AW'(widx) : AW'(widx);
    rd_word = mem[rd_addr];
    rd_pkt  = buf_pkt[rd_ptr];
    tx_byte = 8'h00;
    if (vid_now) begin
      if (byte_idx == BW'(0))      tx_byte = {4'h0, rd_pkt[11:8]};
      else if (byte_idx == BW'(1)) tx_byte = rd_pkt[7:0];
      else if (byte_idx == BW'(2)) tx_byte = rd_crc[15:8];
      else if (byte_idx == BW'(3)) tx_byte = rd_crc[7:0];
      else                         tx_byte = byte_idx[0] ? rd_word[7:0] : rd_word[15:8];
    end else if (byte_idx == BW'(0)) begin
      tx_byte = 8'h0F;
    end
  end

  // An aborted packet leaves the read buffer full, so the same line goes out again
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_miso      <= 1'b0;
      bit_idx       <= '0;
      byte_idx      <= '0;
      is_video      <= 1'b0;
      last_bit      <= 1'b0;
      discard_count <= '0;
    end else if (cs_s) begin
      spi_miso <= 1'b0;
      bit_idx  <= '0;
      byte_idx <= '0;
      last_bit <= 1'b0;
    end else if (fall) begin
      spi_miso <= tx_byte[3'd7 - bit_idx];
      bit_idx  <= bit_idx + 3'd1;
      last_bit <= (byte_idx == BW'(PKT_BYTES - 1)) && (bit_idx == 3'd7);
      if (bit_idx == 3'd7)
        byte_idx <= (byte_idx == BW'(PKT_BYTES - 1)) ? '0 : byte_idx + BW'(1);
      if (pkt_start) begin
        is_video <= vid_now;
        if (!vid_now && discard_count != 16'hFFFF) discard_count <= discard_count + 16'd1;
      end
    end else if (rise) begin
      last_bit <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vospi_slave_tx.sv
// Bench for vospi_slave_tx: SPI mode-3 master plus AXI-S pixel source, packet-level reference model and byte scoreboard.
`timescale 1ns/1ps
module tb_vospi_slave_tx;
  localparam int P  = 8;
  localparam int F  = 6;
  localparam int NB = 2 * P + 4;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic        spi_clk = 1'b1, spi_cs_n = 1'b1;
  logic        spi_miso;
  logic [15:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0;
  logic        tready, frame_error;
  logic [15:0] discard_count;

  always #5 clk = ~clk;

  vospi_slave_tx #(.PIXELS_PER_LINE(P), .PACKETS_PER_FRAME(F), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast), .frame_error(frame_error),
    .discard_count(discard_count)
  );

  int n_cmp = 0, n_fail = 0;
  logic [7:0]       exp_q[$];
  int               m_pkt_q[$];
  logic [16*P-1:0]  m_pix_q[$];
  logic [15:0]      m_part[$];
  int               m_wr_line = 0;
  logic             m_ferr = 1'b0;
  int               m_disc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // A line is kept only if it has all P pixels and tlast exactly on the frame's last line
  function automatic void model_pix(input logic [15:0] d, input logic l);
    logic [16*P-1:0] pk;
    m_part.push_back(d);
    if (l || m_part.size() == P) begin
      if (m_part.size() == P && (l == (m_wr_line == F - 1))) begin
        for (int i = 0; i < P; i++) pk[16*i +: 16] = m_part[i];
        m_pkt_q.push_back(m_wr_line);
        m_pix_q.push_back(pk);
        m_wr_line = (m_wr_line + 1) % F;
      end else begin
        m_ferr    = 1'b1;
        m_wr_line = 0;
      end
      m_part.delete();
    end
  endfunction

  function automatic void push_expected(input int nb);
    logic [7:0]      b[NB];
    logic [16*P-1:0] pk;
    logic [15:0]     crc;
    int              pn;
    for (int j = 0; j < NB; j++) b[j] = 8'h00;
    if (m_pkt_q.size() > 0 && en) begin
      pn   = m_pkt_q[0];
      pk   = m_pix_q[0];
      b[0] = {4'h0, 4'(pn >> 8)};
      b[1] = 8'(pn);
      for (int i = 0; i < P; i++) begin
        b[4 + 2*i] = pk[16*i + 8 +: 8];
        b[5 + 2*i] = pk[16*i +: 8];
      end
      crc = 16'h0000;
`ifdef VOSPI_CRC_EN
      for (int j = 0; j < NB; j++) crc = crc_upd(crc, b[j]);
`endif
      b[2] = crc[15:8];
      b[3] = crc[7:0];
      if (nb == NB) begin
        void'(m_pkt_q.pop_front());
        void'(m_pix_q.pop_front());
      end
    end else begin
      b[0] = 8'h0F;
      if (m_disc < 65535) m_disc++;
    end
    for (int j = 0; j < nb; j++) exp_q.push_back(b[j]);
  endfunction

  task automatic spi_bit();
    @(negedge clk) spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // npkts back-to-back packets under one cs; the last one is cut after last_bytes bytes
  task automatic spi_session(input int npkts, input int last_bytes);
    int nb;
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < npkts; k++) begin
      nb = (k == npkts - 1) ? last_bytes : NB;
      push_expected(nb);
      repeat (nb * 8) spi_bit();
    end
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check("miso_idle", 32'(spi_miso), 32'd0);
  endtask

  task automatic put_pix(input logic [15:0] d, input logic l);
    logic hs;
    hs = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    tdata = d; tlast = l; tvalid = 1'b1;
    for (int t = 0; t < 100 && !hs; t++) begin
      #1;
      if (tready) begin
        @(posedge clk);
        hs = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    #1 tvalid = 1'b0; tlast = 1'b0;
    if (hs) model_pix(d, l);
    else begin
      n_cmp++; n_fail++;
      $display("FAIL pixel_accept: tready stayed 0, required 1");
    end
  endtask

  task automatic write_line(input logic ramp, input int err_pos, input logic omit_last);
    int n;
    logic [15:0] d;
    logic l;
    n = (err_pos >= 0) ? err_pos + 1 : P;
    for (int i = 0; i < n; i++) begin
      d = ramp ? 16'(i) : 16'($urandom_range(0, 65535));
      if (err_pos >= 0) l = (i == err_pos);
      else              l = (i == P - 1) && (m_wr_line == F - 1) && !omit_last;
      put_pix(d, l);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_frame_error"}, 32'(frame_error), 32'(m_ferr));
    check({tag, "_discard_count"}, 32'(discard_count), 32'(m_disc));
  endtask

  // Scoreboard monitor: every received byte is matched against the next expected one
  initial begin : monitor
    logic [7:0] sh;
    int bc;
    bc = 0; sh = '0;
    forever begin
      @(posedge spi_clk or posedge spi_cs_n);
      if (spi_cs_n) bc = 0;
      else begin
        sh = {sh[6:0], spi_miso};
        bc++;
        if (bc == 8) begin
          bc = 0;
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL miso_byte: got %h with no byte expected", sh);
          end else begin
            check("miso_byte", 32'(sh), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic seen;
    int op;
    repeat (5) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_tready", 32'(tready), 32'd0);
    check_status("rst");
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check("tready_empty", 32'(tready), 32'd1);

    // No pixels: discard packet
    spi_session(1, NB);
    check_status("discard");

    // Ramp line 0, then video followed by discard in one cs window
    write_line(1'b1, -1, 1'b0);
    spi_session(2, NB);
    check_status("ramp");

    // Rest of the frame plus first line of the next
    for (int l = 1; l <= F; l++) begin
      write_line(1'b0, -1, 1'b0);
      spi_session(1, NB);
    end
    check_status("frame");

    // Misplaced tlast mid-line 3
    while (m_wr_line != 3) begin
      write_line(1'b0, -1, 1'b0);
      spi_session(1, NB);
    end
    write_line(1'b0, P / 2, 1'b0);
    check_status("tlast_err");
    write_line(1'b0, -1, 1'b0);
    spi_session(1, NB);

    // Both buffers full: tready held low, aborted packet resent intact
    write_line(1'b0, -1, 1'b0);
    write_line(1'b0, -1, 1'b0);
    @(negedge clk) tvalid = 1'b1; tdata = 16'hBEEF;
    seen = 1'b0;
    repeat (20) begin
      #1 if (tready) seen = 1'b1;
      @(negedge clk);
    end
    tvalid = 1'b0;
    check("tready_both_full", 32'(seen), 32'd0);
    spi_session(1, 7);
    spi_session(2, NB);
    check_status("abort");

    for (int it = 0; it < 22; it++) begin
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        if (en && m_pkt_q.size() < 2) begin
          op = $urandom_range(0, 9);
          if (op == 0)      write_line(1'b0, $urandom_range(0, P - 1), 1'b0);
          else if (op == 1) write_line(1'b0, -1, 1'b1);
          else              write_line(1'b0, -1, 1'b0);
        end
      end else if (op == 3) begin
        @(negedge clk) en = ($urandom_range(0, 3) != 0);
      end else begin
        spi_session($urandom_range(1, 2),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, NB - 1) : NB);
      end
    end
    @(negedge clk) en = 1'b1;
    spi_session(m_pkt_q.size() + 1, NB);
    check_status("final");
    check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
